mmu_feeder_nxn: RTL and testbench
=================================

Name: mmu_feeder_nxn

Overview:
Parametrised successor to the 2x2 feeder. Drives an N x N output-stationary systolic array with skewed A/B operand wavefronts, waits for the array to settle, then drains all N*N accumulators as saturated signed DW-bit results over a valid/ready stream. Sits between the host-side operand buffers and the MMU array, and replaces fixed mmu_cycle sequencing with an internal FSM that tolerates backpressure.

Parameters:
N, 2, array dimension (N >= 2)
DW, 8, operand and output width (signed)
ACC_W, 18, array accumulator width (signed); must be >= 2*DW + clog2(N)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; honoured only in IDLE
transpose  in  1  use B transposed; captured with start
weight_flat  in  N*N*DW  A[i][k] at bits (i*N+k)*DW +: DW; captured with start
input_flat  in  N*N*DW  B[k][j] at bits (k*N+j)*DW +: DW; captured with start
c_flat  in  N*N*ACC_W  array accumulator C[i][j] at (i*N+j)*ACC_W +: ACC_W
clear  out  1  array accumulator clear
a_data  out  N*DW  row operands; lane i at i*DW +: DW
b_data  out  N*DW  column operands; lane j at j*DW +: DW
busy  out  1  high from FEED through DRAIN
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_data  out  DW  saturated result
out_idx  out  clog2(N*N)  row-major index i*N+j of out_data
done  out  1  one-cycle pulse after final result accepted

Behaviour:
- Reset (async, rst_n=0): state IDLE, clear=1, a_data=b_data=0, busy=0, out_valid=0, out_idx=0, done=0, all counters 0. Reset mid-operation aborts immediately; captured operands discarded.
- IDLE: clear=1, outputs 0. start=1 captures weight_flat, input_flat and transpose, then next state FEED with k=0.
- FEED, 2N-1 cycles (k=0..2N-2): clear=0. Lane i of a_data = A[i][k-i] if 0 <= k-i < N, else 0. Lane j of b_data = B[k-j][j], or B[j][k-j] when transpose=1, under the same window on k-j, else 0. All operand outputs are registered, so the values for step k are present during FEED cycle k.
- FLUSH, N cycles: a_data=b_data=0 and clear=0, so the last wavefront propagates to PE(N-1,N-1).
- DRAIN: clear=0, out_valid=1, out_idx=d, out_data=sat(C[d/N][d%N]). The out_data path is combinational from c_flat and d. d advances only on out_valid&&out_ready. If out_ready=0, out_idx and out_data hold stable.
- Final handshake (d=N*N-1): next cycle state IDLE, done=1 for one cycle, out_valid=0, clear=1, d=0.
- Saturation: signed ACC_W value v. If v > 2^(DW-1)-1, result is 2^(DW-1)-1. If v < -2^(DW-1), result is -2^(DW-1). Otherwise result is v[DW-1:0].
- start while busy: ignored, with no effect on capture or state.
- transpose or operand changes after capture: no effect until the next start.
- start in the same cycle as done (state already IDLE): accepted.
- Total cycles from start to first out_valid: 1 + (2N-1) + N.

Optional Feature:
Macro MMU_FEEDER_RELU_EN.
- Defined: each saturated result passes through ReLU, so negative values become 0.
- Undefined: signed saturated results are output unchanged.
- Feed, FSM and timing are identical in both builds.

Decomposition:
- Package mmu_pkg holds: the FSM state enum (IDLE, FEED, FLUSH, DRAIN); localparams FEED_CYCLES=2N-1, FLUSH_CYCLES=N, OUT_CNT=N*N; and the function sat_acc(ACC_W->DW).
- One sub-module, mmu_out_sat: combinational select, saturation, and optional ReLU, fed by c_flat and d.
- FSM, capture registers and skew logic stay in mmu_feeder_nxn.

Test Plan:
- Basic multiply: N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], transpose=0, reference array model, out_ready=1 -> out_data sequence 19,22,43,50 with out_idx 0..3; done pulses once; first out_valid 6 cycles after start.
- Transpose: same operands, transpose=1 -> sequence 17,23,39,53.
- Saturation: force C values 200, -300, 127, -128 -> outputs 127, -128, 127, -128. With MMU_FEEDER_RELU_EN defined -> 127, 0, 127, 0.
- Backpressure: out_ready=0 for 5 cycles at d=1 -> out_idx=1 and out_data=22 held stable, no skip and no duplicate; done only after the 4th handshake.
- Protocol edges: start during FEED is ignored; a second start in the done cycle runs a complete second pass; rst_n low mid-DRAIN -> next edge shows IDLE, clear=1, out_valid=0, busy=0.
- Scaling: N=4, A=identity, B=random -> output stream equals B row-major (B^T when transpose=1); a_data lane 3 stays zero until FEED k=3.

Source files
------------

// File: rtl/mmu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmu_pkg
// Description : Shared types and helpers for the N x N systolic-array feeder.
//               FSM state encoding, phase-length helpers and the signed
//               accumulator-to-output saturation function.
//               Optional build macro used by the design: MMU_FEEDER_RELU_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package mmu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } mmu_state_t;

    // Skewed wavefront length: the last lane starts N-1 steps late.
    function automatic int feed_cycles(input int n);
        return 2 * n - 1;
    endfunction

    // Cycles for the last wavefront to reach PE(N-1,N-1).
    function automatic int flush_cycles(input int n);
        return n;
    endfunction

    // Number of accumulators drained per pass.
    function automatic int out_cnt(input int n);
        return n * n;
    endfunction

    // Clamp a sign-extended accumulator into the signed dw-bit range.
    function automatic longint sat_acc(input longint v, input int dw);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (dw - 1)) - longint'(1);
        lo = -hi - longint'(1);
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmu_out_sat.sv
`default_nettype none
// ============================================================================
// Module      : mmu_out_sat
// Description : Selects accumulator C[idx] from the flattened array bus and
//               saturates it to a signed DW-bit result. With the build macro
//               MMU_FEEDER_RELU_EN defined, negative results are forced to 0.
//               Output is zero whenever no result is being presented.
// Revision    : 1.0 - initial release
// ============================================================================
module mmu_out_sat
    import mmu_pkg::*;
#(
    parameter int N     = 2,
    parameter int DW    = 8,
    parameter int ACC_W = 18
) (
    input  logic [N*N*ACC_W-1:0]   c_flat,
    input  logic [$clog2(N*N)-1:0] idx,
    input  logic                   valid,
    output logic [DW-1:0]          data
);

    logic signed [ACC_W-1:0] c_sel;
`ifdef MMU_FEEDER_RELU_EN
    longint                  sat_v;
`endif

    // Combinational select, clamp and optional rectification of one result
    always_comb begin
        c_sel = c_flat[idx*ACC_W +: ACC_W];
`ifdef MMU_FEEDER_RELU_EN
        sat_v = sat_acc(longint'(c_sel), DW);
        data  = (!valid || (sat_v < 0)) ? '0 : DW'(sat_v);
`else
        data  = valid ? DW'(sat_acc(longint'(c_sel), DW)) : '0;
`endif
    end

endmodule
`default_nettype wire

// File: rtl/mmu_feeder_nxn.sv
`default_nettype none
// ============================================================================
// Module      : mmu_feeder_nxn
// Description : Feeds an N x N output-stationary systolic array with skewed
//               A/B wavefronts, waits for the last wavefront to settle, then
//               drains all N*N accumulators as saturated signed DW-bit
//               results over a valid/ready stream.
//               Optional build macro: MMU_FEEDER_RELU_EN (ReLU on results).
// Revision    : 1.0 - initial release
// ============================================================================
module mmu_feeder_nxn
    import mmu_pkg::*;
#(
    parameter int N     = 2,
    parameter int DW    = 8,
    parameter int ACC_W = 18
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   transpose,
    input  logic [N*N*DW-1:0]      weight_flat,
    input  logic [N*N*DW-1:0]      input_flat,
    input  logic [N*N*ACC_W-1:0]   c_flat,
    output logic                   clear,
    output logic [N*DW-1:0]        a_data,
    output logic [N*DW-1:0]        b_data,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_data,
    output logic [$clog2(N*N)-1:0] out_idx,
    output logic                   done
);

    localparam int FEED_CYCLES  = feed_cycles(N);
    localparam int FLUSH_CYCLES = flush_cycles(N);
    localparam int OUT_CNT      = out_cnt(N);
    localparam int IW           = $clog2(OUT_CNT);
    localparam int CW           = $clog2(FEED_CYCLES + 1);

    mmu_state_t          state;
    mmu_state_t          state_nx;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       k_nx;
    logic [IW-1:0]       d;
    logic                done_q;
    logic [N*N*DW-1:0]   a_cap;
    logic [N*N*DW-1:0]   b_cap;
    logic                tr_cap;
    logic [N*N*DW-1:0]   a_src;
    logic [N*N*DW-1:0]   b_src;
    logic                tr_src;
    logic [N*DW-1:0]     a_nx;
    logic [N*DW-1:0]     b_nx;
    logic                last_hs;

    assign last_hs = (state == DRAIN) && out_ready && (d == IW'(OUT_CNT - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: fixed-length FEED/FLUSH, DRAIN ends on the last handshake
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = FEED;
            FEED:    if (cnt == CW'(FEED_CYCLES - 1)) state_nx = FLUSH;
            FLUSH:   if (cnt == CW'(FLUSH_CYCLES - 1)) state_nx = DRAIN;
            DRAIN:   if (last_hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        clear     = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == DRAIN);
    end

    // Phase counter: restarts on every state change, counts within FEED/FLUSH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state_nx != state) begin
            cnt <= '0;
        end else if ((state == FEED) || (state == FLUSH)) begin
            cnt <= cnt + CW'(1);
        end else begin
            cnt <= '0;
        end
    end

    // Operand capture; a start outside IDLE is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cap  <= '0;
            b_cap  <= '0;
            tr_cap <= 1'b0;
        end else if ((state == IDLE) && start) begin
            a_cap  <= weight_flat;
            b_cap  <= input_flat;
            tr_cap <= transpose;
        end
    end

    // Skewed operand selection for the step that the next cycle presents.
    // On the start cycle the capture registers are not yet loaded, so the
    // live inputs are used directly for step 0.
    always_comb begin
        int t;
        t      = 0;
        a_nx   = '0;
        b_nx   = '0;
        a_src  = (state == IDLE) ? weight_flat : a_cap;
        b_src  = (state == IDLE) ? input_flat  : b_cap;
        tr_src = (state == IDLE) ? transpose   : tr_cap;
        k_nx   = (state == IDLE) ? '0 : cnt + CW'(1);
        if (state_nx == FEED) begin
            for (int l = 0; l < N; l++) begin
                t = int'(k_nx) - l;
                if ((t >= 0) && (t < N)) begin
                    a_nx[l*DW +: DW] = a_src[(l*N + t)*DW +: DW];
                    if (tr_src) begin
                        b_nx[l*DW +: DW] = b_src[(l*N + t)*DW +: DW];
                    end else begin
                        b_nx[l*DW +: DW] = b_src[(t*N + l)*DW +: DW];
                    end
                end
            end
        end
    end

    // Registered operand lanes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_data <= '0;
            b_data <= '0;
        end else begin
            a_data <= a_nx;
            b_data <= b_nx;
        end
    end

    // Drain index advances per handshake; done pulses after the final one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d      <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last_hs;
            if ((state == DRAIN) && out_ready) begin
                d <= last_hs ? '0 : d + IW'(1);
            end
        end
    end

    assign out_idx = d;
    assign done    = done_q;

    mmu_out_sat #(
        .N     (N),
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_out_sat (
        .c_flat (c_flat),
        .idx    (d),
        .valid  (out_valid),
        .data   (out_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_mmu_feeder_nxn.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmu_feeder_nxn
// Description : Self-checking bench for mmu_feeder_nxn. Drives an N=2 and an
//               N=4 instance, emulates the systolic array from the operand
//               lanes, and compares every cycle against a matrix-level model.
//               Honours MMU_FEEDER_RELU_EN for the expected results.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mmu_feeder_nxn;

    localparam int DW = 8;
    localparam int AW = 18;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // N=2 instance
    logic         start0 = 1'b0, tr0 = 1'b0, rdy0 = 1'b1;
    logic [31:0]  w0 = '0, in0 = '0;
    logic [71:0]  c0 = '0;
    logic         clear0, busy0, ov0, done0;
    logic [15:0]  a0, b0;
    logic [7:0]   od0;
    logic [1:0]   oi0;

    // N=4 instance
    logic         start1 = 1'b0, tr1 = 1'b0, rdy1 = 1'b1;
    logic [127:0] w1 = '0, in1 = '0;
    logic [287:0] c1 = '0;
    logic         clear1, busy1, ov1, done1;
    logic [31:0]  a1, b1;
    logic [7:0]   od1;
    logic [3:0]   oi1;

    mmu_feeder_nxn #(.N(2), .DW(DW), .ACC_W(AW)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start0), .transpose(tr0),
        .weight_flat(w0), .input_flat(in0), .c_flat(c0), .clear(clear0),
        .a_data(a0), .b_data(b0), .busy(busy0), .out_valid(ov0),
        .out_ready(rdy0), .out_data(od0), .out_idx(oi0), .done(done0)
    );

    mmu_feeder_nxn #(.N(4), .DW(DW), .ACC_W(AW)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start1), .transpose(tr1),
        .weight_flat(w1), .input_flat(in1), .c_flat(c1), .clear(clear1),
        .a_data(a1), .b_data(b1), .busy(busy1), .out_valid(ov1),
        .out_ready(rdy1), .out_data(od1), .out_idx(oi1), .done(done1)
    );

    // Uniform views of both instances
    logic [31:0]  v_a[2], v_b[2];
    logic [127:0] v_w[2], v_in[2];
    logic [7:0]   v_od[2];
    logic         v_clear[2], v_busy[2], v_ov[2], v_done[2], v_start[2], v_tr[2], v_rdy[2];
    int           v_oi[2];
    assign v_a[0] = {16'd0, a0};     assign v_a[1] = a1;
    assign v_b[0] = {16'd0, b0};     assign v_b[1] = b1;
    assign v_w[0] = {96'd0, w0};     assign v_w[1] = w1;
    assign v_in[0] = {96'd0, in0};   assign v_in[1] = in1;
    assign v_od[0] = od0;            assign v_od[1] = od1;
    assign v_oi[0] = {30'd0, oi0};   assign v_oi[1] = {28'd0, oi1};
    assign v_clear[0] = clear0;      assign v_clear[1] = clear1;
    assign v_busy[0] = busy0;        assign v_busy[1] = busy1;
    assign v_ov[0] = ov0;            assign v_ov[1] = ov1;
    assign v_done[0] = done0;        assign v_done[1] = done1;
    assign v_start[0] = start0;      assign v_start[1] = start1;
    assign v_tr[0] = tr0;            assign v_tr[1] = tr1;
    assign v_rdy[0] = rdy0;          assign v_rdy[1] = rdy1;

    int NN[2] = '{2, 4};

    // Matrix-level model: captured operands, cycles since start, drain index
    int mA[2][4][4], mB[2][4][4];
    bit mtr[2];
    int mt[2], md[2];
    bit mdone[2];

    // Array emulation: lane history [inst][delay][lane] and accumulators
    int ha[2][4][4], hb[2][4][4];
    int emC[2][4][4];
    bit force_c = 1'b0;
    int fval[4];

    int log0[$], log1[$];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 60) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int s8(input logic [7:0] x);
        return int'($signed(x));
    endfunction

    function automatic int exp_lane(input int u, input bit isb, input int k, input int l);
        int n, t;
        n = NN[u];
        t = k - l;
        if (t < 0 || t >= n) return 0;
        if (!isb) return mA[u][l][t];
        return mtr[u] ? mB[u][l][t] : mB[u][t][l];
    endfunction

    function automatic int exp_res(input int u, input int d);
        int n, i, j, s;
        n = NN[u]; i = d / n; j = d % n; s = 0;
        if (u == 0 && force_c) s = fval[d];
        else for (int k = 0; k < n; k++) s += mA[u][i][k] * (mtr[u] ? mB[u][j][k] : mB[u][k][j]);
        if (s > 127) s = 127;
        if (s < -128) s = -128;
`ifdef MMU_FEEDER_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    // Array emulation and model update at each rising edge
    initial forever begin
        logic [71:0]  t0;
        logic [287:0] t1;
        @(posedge clk);
        for (int u = 0; u < 2; u++) begin
            int n;
            n = NN[u];
            for (int dl = 3; dl > 0; dl--)
                for (int l = 0; l < 4; l++) begin
                    ha[u][dl][l] = ha[u][dl-1][l];
                    hb[u][dl][l] = hb[u][dl-1][l];
                end
            for (int l = 0; l < 4; l++) begin
                ha[u][0][l] = (l < n) ? s8(v_a[u][l*8 +: 8]) : 0;
                hb[u][0][l] = (l < n) ? s8(v_b[u][l*8 +: 8]) : 0;
            end
            for (int i = 0; i < n; i++)
                for (int j = 0; j < n; j++)
                    if (v_clear[u]) emC[u][i][j] = 0;
                    else emC[u][i][j] += ha[u][j][i] * hb[u][i][j];
            if (!rst_n) begin
                mt[u] = 0; md[u] = 0; mdone[u] = 1'b0;
            end else begin
                mdone[u] = 1'b0;
                if (mt[u] == 0) begin
                    if (v_start[u]) begin
                        for (int i = 0; i < n; i++)
                            for (int k = 0; k < n; k++) begin
                                mA[u][i][k] = s8(v_w[u][(i*n+k)*8 +: 8]);
                                mB[u][i][k] = s8(v_in[u][(i*n+k)*8 +: 8]);
                            end
                        mtr[u] = v_tr[u];
                        mt[u] = 1;
                    end
                end else if (mt[u] < 3*n) begin
                    mt[u]++;
                end else if (v_rdy[u]) begin
                    if (u == 0) log0.push_back(s8(v_od[0]));
                    else log1.push_back(s8(v_od[1]));
                    if (md[u] == n*n - 1) begin
                        md[u] = 0; mt[u] = 0; mdone[u] = 1'b1;
                    end else begin
                        md[u]++;
                    end
                end
            end
        end
        t0 = '0;
        t1 = '0;
        for (int i = 0; i < 4; i++) t0[i*AW +: AW] = force_c ? AW'(fval[i]) : AW'(emC[0][i/2][i%2]);
        for (int i = 0; i < 16; i++) t1[i*AW +: AW] = AW'(emC[1][i/4][i%4]);
        c0 <= t0;
        c1 <= t1;
    end

    // Per-cycle compare of both instances against the model
    initial forever begin
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            int n, k;
            n = NN[u];
            if (!rst_n) begin
                chk("rst_clear", int'(v_clear[u]), 1);
                chk("rst_busy", int'(v_busy[u]), 0);
                chk("rst_valid", int'(v_ov[u]), 0);
                chk("rst_done", int'(v_done[u]), 0);
                chk("rst_idx", v_oi[u], 0);
                chk("rst_a", int'(v_a[u]), 0);
                chk("rst_b", int'(v_b[u]), 0);
            end else begin
                chk("clear", int'(v_clear[u]), (mt[u] == 0) ? 1 : 0);
                chk("busy", int'(v_busy[u]), (mt[u] != 0) ? 1 : 0);
                chk("out_valid", int'(v_ov[u]), (mt[u] == 3*n) ? 1 : 0);
                chk("done", int'(v_done[u]), int'(mdone[u]));
                k = (mt[u] >= 1 && mt[u] <= 2*n - 1) ? mt[u] - 1 : -100;
                for (int l = 0; l < n; l++) begin
                    chk("a_lane", s8(v_a[u][l*8 +: 8]), exp_lane(u, 1'b0, k, l));
                    chk("b_lane", s8(v_b[u][l*8 +: 8]), exp_lane(u, 1'b1, k, l));
                end
                chk("out_idx", v_oi[u], (mt[u] == 3*n) ? md[u] : 0);
                if (mt[u] == 3*n) chk("out_data", s8(v_od[u]), exp_res(u, md[u]));
            end
        end
    end

    task automatic wait_done(input int u, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (v_done[u]) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic check_log0(input string nm, input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        chk({nm, "_len"}, log0.size(), 4);
        for (int i = 0; i < 4; i++) chk(nm, (i < log0.size()) ? log0[i] : -999, e[i]);
    endtask

    task automatic run0(input string nm, input int e0, input int e1, input int e2, input int e3);
        log0.delete();
        start0 = 1'b1;
        @(negedge clk); #1 start0 = 1'b0;
        wait_done(0, 200);
        check_log0(nm, e0, e1, e2, e3);
        #1;
    endtask

    task automatic wait_idx0(input int idx);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (ov0 && int'(oi0) == idx) return;
        end
        chk("idx_timeout", 0, 1);
    endtask

    task automatic run1_check(input string nm, input bit trn);
        log1.delete();
        tr1 = trn;
        start1 = 1'b1;
        @(negedge clk); chk("lane3_k0", s8(a1[31:24]), 0);
        #1 start1 = 1'b0;
        @(negedge clk); chk("lane3_k1", s8(a1[31:24]), 0);
        @(negedge clk); chk("lane3_k2", s8(a1[31:24]), 0);
        wait_done(1, 300);
        chk({nm, "_len"}, log1.size(), 16);
        for (int d = 0; d < 16; d++) begin
            int i, j, src;
            i = d / 4; j = d % 4;
            src = trn ? (j*4 + i) : (i*4 + j);
            chk(nm, (d < log1.size()) ? log1[d] : -999, s8(in1[src*8 +: 8]));
        end
        #1;
    endtask

    initial begin
        int lat;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // Basic multiply, with first-valid latency
        w0 = {8'd4, 8'd3, 8'd2, 8'd1};
        in0 = {8'd8, 8'd7, 8'd6, 8'd5};
        tr0 = 1'b0;
        log0.delete();
        start0 = 1'b1;
        for (lat = 1; lat <= 20; lat++) begin
            @(negedge clk);
            if (ov0) break;
            #1 start0 = 1'b0;
        end
        chk("first_valid_latency", lat, 6);
        wait_done(0, 200);
        check_log0("basic", 19, 22, 43, 50);
        #1;

        // Transpose
        tr0 = 1'b1;
        run0("transpose", 17, 23, 39, 53);

        // Backpressure at d=1
        tr0 = 1'b0;
        log0.delete();
        start0 = 1'b1;
        @(negedge clk); #1 start0 = 1'b0;
        wait_idx0(1);
        #1 rdy0 = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_idx", int'(oi0), 1);
            chk("bp_data", s8(od0), 22);
        end
        #1 rdy0 = 1'b1;
        wait_done(0, 200);
        check_log0("backpressure", 19, 22, 43, 50);
        #1;

        // Saturation with forced accumulators
        force_c = 1'b1;
        fval = '{200, -300, 127, -128};
`ifdef MMU_FEEDER_RELU_EN
        run0("saturate", 127, 0, 127, 0);
`else
        run0("saturate", 127, -128, 127, -128);
`endif
        force_c = 1'b0;

        // Start during FEED is ignored; start in the done cycle is accepted
        log0.delete();
        start0 = 1'b1;
        @(negedge clk); #1 start0 = 1'b0;
        w0 = 32'h0909_0909;
        tr0 = 1'b1;
        start0 = 1'b1;
        @(negedge clk); #1 start0 = 1'b0;
        wait_done(0, 200);
        check_log0("feed_restart", 19, 22, 43, 50);
        #1 w0 = {8'd4, 8'd3, 8'd2, 8'd1};
        log0.delete();
        start0 = 1'b1;
        @(negedge clk); #1 start0 = 1'b0;
        wait_done(0, 200);
        check_log0("done_cycle_start", 17, 23, 39, 53);
        #1;

        // Reset mid-DRAIN
        tr0 = 1'b0;
        log0.delete();
        start0 = 1'b1;
        @(negedge clk); #1 start0 = 1'b0;
        wait_idx0(2);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_clear", int'(clear0), 1);
        chk("midrst_valid", int'(ov0), 0);
        chk("midrst_busy", int'(busy0), 0);
        #1 rst_n = 1'b1;
        run0("after_reset", 19, 22, 43, 50);

        // N=4: identity A reproduces B, or B^T with transpose
        w1 = '0;
        for (int i = 0; i < 4; i++) w1[(i*4 + i)*8 +: 8] = 8'd1;
        for (int i = 0; i < 16; i++) in1[i*8 +: 8] = 8'($urandom_range(0, 255));
        run1_check("n4_identity", 1'b0);
        run1_check("n4_transpose", 1'b1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
